frv_wb_arb: RTL

Two-port Wishbone arbiter that lets the FazyRV core's instruction bus (imem) and data bus (dmem) share one memory-side Wishbone port. It sits between the core wrapper and the single SRAM/peripheral interconnect port of the macro. It grants one bus at a time with round-robin fairness, routes the handshake, and aborts hung transfers with a bus-timeout.

---
 rtl/frv_wb_arb_pkg.sv | 25 ++
 rtl/frv_wb_tmo.sv | 45 ++++
 rtl/frv_wb_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/frv_wb_arb_pkg.sv
// Shared types and constants for the FazyRV two-port Wishbone arbiter.
//   arb_state_e      : arbiter FSM states
//   GNT_IMEM/DMEM    : bit positions of the grant vector
//   ERR_DATA_DEFAULT : read data handed back on a timeout abort
package frv_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    localparam int unsigned GNT_IMEM = 0;
    localparam int unsigned GNT_DMEM = 1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Tie-break between two simultaneous requests: serve the master that
    // was not served last.
    function automatic arb_state_e tie_winner(input logic last_dmem);
        return last_dmem ? GNT_I : GNT_D;
    endfunction

endpackage

// File: rtl/frv_wb_tmo.sv
// Bus-timeout wait counter for the arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the counter (held while no transfer is granted)
//   en       : count one waiting cycle
//   expired  : counter has reached TIMEOUT-1; constant 0 when TIMEOUT = 0
// The 8-bit counter saturates at 255 instead of wrapping.
module frv_wb_tmo #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_disabled
        logic unused_inputs;
        assign unused_inputs = clk ^ rst ^ clr ^ en;
        assign expired = 1'b0;
    end else begin : g_counter
        logic [7:0] cnt_q;
        logic [7:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = 8'd0;
            end else if (en && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired = (cnt_q == 8'(TIMEOUT - 1));
    end

endmodule

// File: rtl/frv_wb_arb.sv
// Two-port Wishbone arbiter: FazyRV imem and dmem share one memory port.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wb_imem_*         : instruction master (read-only) request / response
//   wb_dmem_*         : data master request / response
//   m_*               : shared memory-side Wishbone port
//   gnt_o             : current grant, bit GNT_IMEM / GNT_DMEM, one-hot or zero
//   timeout_o         : sticky flag, set when any transfer is aborted
// One grant at a time, round-robin on ties, an IDLE bubble between grants and
// an ABORT cycle that completes a hung transfer with ERR_DATA.
module frv_wb_arb
    import frv_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        wb_imem_cyc_i,
    input  logic        wb_imem_stb_i,
    input  logic [31:0] wb_imem_adr_i,
    output logic [31:0] wb_imem_dat_o,
    output logic        wb_imem_ack_o,

    input  logic        wb_dmem_cyc_i,
    input  logic        wb_dmem_stb_i,
    input  logic        wb_dmem_we_i,
    input  logic [3:0]  wb_dmem_be_i,
    input  logic [31:0] wb_dmem_adr_i,
    input  logic [31:0] wb_dmem_dat_i,
    output logic [31:0] wb_dmem_dat_o,
    output logic        wb_dmem_ack_o,

    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_dmem_q, last_dmem_d;  // 1: dmem was served last
    logic       timeout_q, timeout_d;

    logic imem_req;
    logic dmem_req;
    logic granted;
    logic tmo_expired;

    assign imem_req = wb_imem_cyc_i & wb_imem_stb_i;
    assign dmem_req = wb_dmem_cyc_i & wb_dmem_stb_i;
    assign granted  = (state_q == GNT_I) || (state_q == GNT_D);

    // Holding the counter clear outside GNT states makes it start at zero on
    // every grant entry.
    frv_wb_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (!granted),
        .en      (granted && !m_ack_i),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        last_dmem_d = last_dmem_q;
        timeout_d   = timeout_q;

        m_cyc_o       = 1'b0;
        m_stb_o       = 1'b0;
        m_we_o        = 1'b0;
        m_be_o        = 4'h0;
        m_adr_o       = 32'h0;
        m_dat_o       = 32'h0;
        wb_imem_ack_o = 1'b0;
        wb_imem_dat_o = 32'h0;
        wb_dmem_ack_o = 1'b0;
        wb_dmem_dat_o = 32'h0;
        gnt_o         = 2'b00;

        case (state_q)
            IDLE: begin
                if (imem_req && dmem_req) begin
                    state_d = tie_winner(last_dmem_q);
                end else if (imem_req) begin
                    state_d = GNT_I;
                end else if (dmem_req) begin
                    state_d = GNT_D;
                end
            end

            GNT_I: begin
                gnt_o[GNT_IMEM] = 1'b1;
                m_cyc_o         = imem_req;
                m_stb_o         = imem_req;
                m_be_o          = 4'hF;
                m_adr_o         = wb_imem_adr_i;
                wb_imem_ack_o   = m_ack_i;
                wb_imem_dat_o   = m_dat_i;
                if (m_ack_i) begin
                    last_dmem_d = 1'b0;
                    state_d     = IDLE;
                end else if (!wb_imem_cyc_i) begin
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    // last is recorded now so ABORT knows whom to ack
                    last_dmem_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = ABORT;
                end
            end

            GNT_D: begin
                gnt_o[GNT_DMEM] = 1'b1;
                m_cyc_o         = dmem_req;
                m_stb_o         = dmem_req;
                m_we_o          = wb_dmem_we_i;
                m_be_o          = wb_dmem_be_i;
                m_adr_o         = wb_dmem_adr_i;
                m_dat_o         = wb_dmem_dat_i;
                wb_dmem_ack_o   = m_ack_i;
                wb_dmem_dat_o   = m_dat_i;
                if (m_ack_i) begin
                    last_dmem_d = 1'b1;
                    state_d     = IDLE;
                end else if (!wb_dmem_cyc_i) begin
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    last_dmem_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = ABORT;
                end
            end

            ABORT: begin
                if (last_dmem_q) begin
                    wb_dmem_ack_o = 1'b1;
                    wb_dmem_dat_o = ERR_DATA;
                end else begin
                    wb_imem_ack_o = 1'b1;
                    wb_imem_dat_o = ERR_DATA;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_dmem_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dmem_q <= last_dmem_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule
